// File: rtl/g2_pkg.sv
// Shared types and constants for the g2 acquisition sequencer.
package g2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        FLUSH,
        STROBE,
        DUMP,
        DONE
    } g2AcqState_t;

    localparam int G2_BINS      = 1024;
    // Readout strobe must trail the last accepted timestamp by at least this much.
    localparam int G2_FLUSH_MIN = 2;

endpackage

// File: rtl/g2_acq_sequencer_if.sv
// Timestamp gating and histogram readout streams around the g2 sequencer.
interface g2_acq_sequencer_if #(
    parameter int iSIZE  = 31,
    parameter int binBit = 9
);
    logic             a1Vi, a1Ri, a1Vo, a1Ro;
    logic             a2Vi, a2Ri, a2Vo, a2Ro;
    logic [iSIZE:0]   g2Dat;
    logic             g2V, g2R;
    logic [iSIZE:0]   outDat;
    logic [binBit:0]  outBin;
    logic             outV, outR, outLast;

    // Sequencer side.
    modport slave (
        input  a1Vi, a1Ro, a2Vi, a2Ro, g2Dat, g2V, outR,
        output a1Ri, a1Vo, a2Ri, a2Vo, g2R, outDat, outBin, outV, outLast
    );

    // Sources, calculator and host side.
    modport master (
        output a1Vi, a1Ro, a2Vi, a2Ro, g2Dat, g2V, outR,
        input  a1Ri, a1Vo, a2Ri, a2Vo, g2R, outDat, outBin, outV, outLast
    );
endinterface

// File: rtl/g2_stream_gate.sv
// Valid/ready gate for one timestamp stream; closed means neither side sees a beat.
module g2_stream_gate (
    input  logic en_i,
    input  logic vi_i,
    output logic ri_o,
    output logic vo_o,
    input  logic ro_i
);
    assign vo_o = en_i & vi_i;
    assign ri_o = en_i & ro_i;
endmodule

// File: rtl/g2_acq_sequencer.sv
// Frame sequencer: timed acquisition window, drain, histogram readout strobe, bin dump.
module g2_acq_sequencer
    import g2_pkg::*;
#(
    parameter int iSIZE    = 31,
    parameter int binBit   = $clog2(G2_BINS) - 1,
    parameter int winBit   = 31,
    parameter int flushCyc = 16,
    parameter int frmBit   = 15
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
    input  logic [winBit:0]   cfgWindow,
    output logic              histRst,
    output logic              busy,
    output logic [frmBit:0]   frameCnt,
    g2_acq_sequencer_if.slave bus
);
    localparam int FLUSH_N = (flushCyc < G2_FLUSH_MIN) ? G2_FLUSH_MIN : flushCyc;
    localparam int FLW     = $clog2(FLUSH_N);

    g2AcqState_t      state_q, state_d;
    logic [winBit:0]  winCnt_q, winCnt_d;
    logic [winBit:0]  winLen_q, winLen_d;
    logic [FLW-1:0]   flushCnt_q, flushCnt_d;
    logic [binBit:0]  binCnt_q, binCnt_d;
    logic [frmBit:0]  frameCnt_q, frameCnt_d;
    logic             contLatch_q, contLatch_d;
    logic             histRst_q;
    logic [winBit:0]  cfgLen;
    logic             inDump, beat;
    logic [iSIZE:0]   g2DatW;

    // A zero-length window still opens the gate for one cycle.
    assign cfgLen = (cfgWindow == '0) ? {{winBit{1'b0}}, 1'b1} : cfgWindow;
    assign inDump = (state_q == DUMP);
    assign beat   = inDump & bus.g2V & bus.outR;

    always_comb begin
        state_d     = state_q;
        winCnt_d    = winCnt_q;
        winLen_d    = winLen_q;
        flushCnt_d  = flushCnt_q;
        binCnt_d    = binCnt_q;
        frameCnt_d  = frameCnt_q;
        contLatch_d = contLatch_q & ~stop;
        unique case (state_q)
            IDLE: if (start) begin
                state_d     = ACQ;
                winLen_d    = cfgLen;
                winCnt_d    = '0;
                contLatch_d = cont & ~stop;
            end
            ACQ: begin
                winCnt_d = winCnt_q + 1'b1;
                if (stop || winCnt_q == winLen_q - 1'b1) begin
                    state_d    = FLUSH;
                    flushCnt_d = '0;
                end
            end
            FLUSH: begin
                flushCnt_d = flushCnt_q + 1'b1;
                if (flushCnt_q == FLW'(FLUSH_N - 1)) state_d = STROBE;
            end
            STROBE: begin
                state_d  = DUMP;
                binCnt_d = '0;
            end
            // Readout is destructive, so stop never cuts a dump short.
            DUMP: if (beat) begin
                binCnt_d = binCnt_q + 1'b1;
                if (&binCnt_q) state_d = DONE;
            end
            DONE: begin
                frameCnt_d = frameCnt_q + 1'b1;
                if (contLatch_q && !stop) begin
                    state_d  = ACQ;
                    winLen_d = cfgLen;
                    winCnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            winCnt_q    <= '0;
            winLen_q    <= '0;
            flushCnt_q  <= '0;
            binCnt_q    <= '0;
            frameCnt_q  <= '0;
            contLatch_q <= 1'b0;
            histRst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            winCnt_q    <= winCnt_d;
            winLen_q    <= winLen_d;
            flushCnt_q  <= flushCnt_d;
            binCnt_q    <= binCnt_d;
            frameCnt_q  <= frameCnt_d;
            contLatch_q <= contLatch_d;
            // Registered so the calculator reset is glitch-free and low only in STROBE.
            histRst_q   <= (state_d != STROBE);
        end
    end

    logic [1:0] vi, ri, vo, ro;
    assign vi = {bus.a2Vi, bus.a1Vi};
    assign ro = {bus.a2Ro, bus.a1Ro};

    for (genvar s = 0; s < 2; s++) begin : g_gate
        g2_stream_gate u_gate (
            .en_i (state_q == ACQ),
            .vi_i (vi[s]),
            .ri_o (ri[s]),
            .vo_o (vo[s]),
            .ro_i (ro[s])
        );
    end

    assign bus.a1Vo = vo[0];
    assign bus.a1Ri = ri[0];
    assign bus.a2Vo = vo[1];
    assign bus.a2Ri = ri[1];

    assign g2DatW      = bus.g2Dat;
    assign bus.g2R     = inDump & bus.outR;
    assign bus.outV    = inDump & bus.g2V;
    assign bus.outDat  = inDump ? g2DatW : '0;
    assign bus.outBin  = inDump ? binCnt_q : '0;
    assign bus.outLast = inDump & (&binCnt_q);

    assign histRst  = histRst_q;
    assign busy     = (state_q != IDLE);
    assign frameCnt = frameCnt_q;
endmodule

// File: tb/tb_g2_acq_sequencer.sv
// Directed bench for g2_acq_sequencer: window length, drain gap, dump ordering, stop/cont, reset.
module tb_g2_acq_sequencer;
    import g2_pkg::*;

    logic        clk = 1'b0;
    logic        RST;
    logic        start, stop, cont;
    logic [31:0] cfgWindow;
    logic        histRst, busy;
    logic [15:0] frameCnt;

    g2_acq_sequencer_if bus ();

    g2_acq_sequencer dut (
        .clk       (clk),
        .RST       (RST),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .cfgWindow (cfgWindow),
        .histRst   (histRst),
        .busy      (busy),
        .frameCnt  (frameCnt),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;

    int acqN, a2N, strobeN, gapN, beatN, lastN;
    int binErr, datErr, lastErr, g2rErr, gateErr, finished;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
    endtask

    // Runs from a start pulse (or held start) until busy falls, collecting statistics.
    task automatic run_frame(input bit holdStart, input int stopAcq, input int stopDump,
                             input bit toggleR);
        bit seenBusy = 0;
        int lastAcq = -1, dumpIdx = 0, dumpBeats = 0, expBin = 0;
        acqN = 0; a2N = 0; strobeN = 0; gapN = -1; beatN = 0; lastN = 0;
        binErr = 0; datErr = 0; lastErr = 0; g2rErr = 0; gateErr = 0; finished = 0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || holdStart;
            stop  = ((stopAcq >= 0) && (acqN == stopAcq) && bus.a1Vo) ||
                    ((dumpIdx == stopDump) && (dumpBeats == 500));
            bus.outR  = toggleR ? ((cyc % 2) == 0) : 1'b1;
            bus.g2Dat = 32'hC0DE_0000 + 32'(expBin);
            #1;
            if (bus.a1Vo) begin acqN++; lastAcq = cyc; end
            if (bus.a2Vo) a2N++;
            if (bus.a1Ri !== bus.a1Vo || bus.a2Ri !== bus.a1Vo || bus.a2Vo !== bus.a1Vo) gateErr++;
            if (histRst === 1'b0) begin
                strobeN++; gapN = cyc - lastAcq; dumpIdx++; dumpBeats = 0;
            end
            if (bus.g2R !== (bus.outV & bus.outR)) g2rErr++;
            if (bus.outV && bus.outR) begin
                if (bus.outBin !== 10'(expBin)) binErr++;
                if (bus.outDat !== 32'hC0DE_0000 + 32'(expBin)) datErr++;
                if (bus.outLast) lastN++;
                if (bus.outLast !== (expBin == G2_BINS - 1)) lastErr++;
                beatN++; dumpBeats++;
                expBin = (expBin + 1) % G2_BINS;
            end
            if (busy) seenBusy = 1;
            else if (seenBusy) begin finished = 1; break; end
        end
        start = 1'b0;
        stop  = 1'b0;
        check("frame_terminated", finished, 1);
    endtask

    initial begin
        int n;
        RST = 1'b0; start = 0; stop = 0; cont = 0; cfgWindow = 32'd100;
        bus.a1Vi = 1; bus.a2Vi = 1; bus.a1Ro = 1; bus.a2Ro = 1;
        bus.g2V = 1; bus.outR = 1; bus.g2Dat = '0;

        // Reset values
        #12;
        check("rst_histRst", histRst, 1);
        check("rst_busy", busy, 0);
        check("rst_frameCnt", frameCnt, 0);
        check("rst_a1Vo", bus.a1Vo, 0);
        check("rst_a1Ri", bus.a1Ri, 0);
        check("rst_a2Vo", bus.a2Vo, 0);
        check("rst_g2R", bus.g2R, 0);
        check("rst_outV", bus.outV, 0);
        check("rst_outLast", bus.outLast, 0);
        check("rst_outBin", bus.outBin, 0);
        RST = 1'b1;
        @(negedge clk);

        // Plain 100-cycle frame; strobe lands after 16 drain cycles (gap 17 from last ACQ cycle)
        cfgWindow = 32'd100; cont = 0;
        run_frame(0, -1, -1, 0);
        check("t1_acq_cycles", acqN, 100);
        check("t1_a2_cycles", a2N, 100);
        check("t1_gate", gateErr, 0);
        check("t1_strobes", strobeN, 1);
        check("t1_strobe_gap", gapN, 17);
        check("t1_beats", beatN, G2_BINS);
        check("t1_bin_order", binErr, 0);
        check("t1_data", datErr, 0);
        check("t1_last_count", lastN, 1);
        check("t1_last_pos", lastErr, 0);
        check("t1_g2R", g2rErr, 0);
        check("t1_frameCnt", frameCnt, 1);
        check("t1_idle", busy, 0);

        // Early stop at ACQ cycle 37
        do_reset();
        cfgWindow = 32'd1000;
        run_frame(0, 37, -1, 0);
        check("t2_acq_cycles", acqN, 38);
        check("t2_strobe_gap", gapN, 17);
        check("t2_beats", beatN, G2_BINS);
        check("t2_bin_order", binErr, 0);
        check("t2_frameCnt", frameCnt, 1);

        // Continuous mode, stop in the second dump
        do_reset();
        cfgWindow = 32'd50; cont = 1;
        run_frame(0, -1, 2, 0);
        cont = 0;
        check("t3_acq_cycles", acqN, 100);
        check("t3_strobes", strobeN, 2);
        check("t3_beats", beatN, 2 * G2_BINS);
        check("t3_last_count", lastN, 2);
        check("t3_bin_order", binErr, 0);
        check("t3_frameCnt", frameCnt, 2);
        n = 0;
        repeat (60) begin @(negedge clk); #1; if (busy) n++; end
        check("t3_no_third_acq", n, 0);

        // outR toggling every cycle during dump
        do_reset();
        cfgWindow = 32'd10;
        run_frame(0, -1, -1, 1);
        check("t4_beats", beatN, G2_BINS);
        check("t4_bin_order", binErr, 0);
        check("t4_data", datErr, 0);
        check("t4_g2R_mirror", g2rErr, 0);
        check("t4_last_pos", lastErr, 0);
        check("t4_frameCnt", frameCnt, 1);

        // Async reset in the 20th ACQ cycle, with a frame already counted
        cfgWindow = 32'd100; n = 0;
        for (int c = 0; c < 200 && n < 20; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            if (bus.a1Vo) n++;
        end
        start = 0;
        check("t5_acq_reached", n, 20);
        #2 RST = 1'b0;
        #1;
        check("t5_a1Vo", bus.a1Vo, 0);
        check("t5_a1Ri", bus.a1Ri, 0);
        check("t5_histRst", histRst, 1);
        check("t5_busy", busy, 0);
        check("t5_frameCnt", frameCnt, 0);
        check("t5_outV", bus.outV, 0);
        @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        run_frame(0, -1, -1, 0);
        check("t5_acq_cycles", acqN, 100);
        check("t5_beats", beatN, G2_BINS);
        check("t5_frameCnt", frameCnt, 1);

        // Zero window with start held for the whole frame
        do_reset();
        cfgWindow = 32'd0;
        run_frame(1, -1, -1, 0);
        check("t6_acq_cycles", acqN, 1);
        check("t6_strobes", strobeN, 1);
        check("t6_strobe_gap", gapN, 17);
        check("t6_beats", beatN, G2_BINS);
        check("t6_frameCnt", frameCnt, 1);
        repeat (3) @(negedge clk);
        #1;
        check("t6_stays_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/g2_acq_sequencer.md
Name: g2_acq_sequencer

Overview:
- Frame-level controller for the g2 correlation datapath. Sequences one acquisition frame: gates the a1/a2 timestamp streams into the calculator for a programmed window, then lets in-flight writes drain.
- Then pulses the histogram reset/readout strobe and forwards every histogram bin to a downstream consumer, tagged with bin index and end-of-frame.
- Sits between the timestamp sources and the g2 calculator on the input side, and between the calculator's g2Dat/g2V/g2R port and the host stream on the output side.

Parameters:
- iSIZE, 31, MSB index of timestamp and histogram data words.
- binBit, 9, MSB index of bin address; bins = 2^(binBit+1) = 1024.
- winBit, 31, MSB index of window cycle counter.
- flushCyc, 16, drain cycles between window end and readout strobe (must be >= 2).
- frmBit, 15, MSB index of frame counter.

Ports:
- clk  in  1  clock.
- RST  in  1  reset; asynchronous, active-low.
- start  in  1  level; begins a frame from IDLE.
- stop  in  1  pulse; ends the window early and cancels continuous mode.
- cont  in  1  continuous mode, sampled at start.
- cfgWindow  in  winBit+1  window length in cycles, latched at start.
- a1Vi / a1Ri  in / out  1 / 1  upstream a1 valid / ready.
- a1Vo / a1Ro  out / in  1 / 1  to calculator a1V / from a1R.
- a2Vi / a2Ri / a2Vo / a2Ro  as a1, for the a2 stream (data buses bypass this block).
- histRst  out  1  drives the calculator RST (falling-edge readout strobe); idles high.
- g2Dat  in  iSIZE+1  histogram word from calculator.
- g2V  in  1  histogram word valid.
- g2R  out  1  histogram word accept.
- outDat  out  iSIZE+1  forwarded bin value.
- outBin  out  binBit+1  bin index of outDat.
- outV / outR  out / in  1 / 1  output stream handshake.
- outLast  out  1  high with the final bin of a frame.
- busy  out  1  high in every state except IDLE.
- frameCnt  out  frmBit+1  completed frames, wraps.

Behaviour:
- Reset (RST low, async): state IDLE, histRst=1, all valid/ready outputs 0, g2R=0, outV=0, outLast=0, outBin=0, frameCnt=0, internal counters 0, contLatch=0. A reset mid-frame abandons the frame; the calculator's histogram is not cleared by this block.
- Gating:
  - In ACQ: a1Vo=a1Vi, a1Ri=a1Ro (same for a2).
  - In all other states: a1Vo=a2Vo=0 and a1Ri=a2Ri=0. No beat is ever lost.
- States IDLE, ACQ, FLUSH, STROBE, DUMP, DONE.
- IDLE -> ACQ when start=1:
  - Latch cfgWindow (a value of 0 is treated as 1) and cont.
  - winCnt=0.
- ACQ:
  - winCnt increments each cycle.
  - Go to FLUSH when winCnt == window-1, or when stop=1 (stop also clears contLatch).
  - If stop and the terminal count coincide, exit once and clear contLatch.
- FLUSH: hold flushCyc cycles, then go to STROBE.
- STROBE:
  - histRst=0 for exactly one cycle, then return to 1. histRst is guaranteed high the cycle before.
  - Next state DUMP; binCnt=0.
- DUMP:
  - g2R=outR, outV=g2V, outDat=g2Dat, outBin=binCnt, outLast=(binCnt==all ones). Combinational pass-through, zero latency.
  - binCnt increments on each g2V&&outR.
  - After the handshake with outLast, go to DONE.
  - stop in DUMP clears contLatch only; the dump always completes, because readout clears bins.
  - outR low stalls indefinitely.
- DONE (1 cycle):
  - frameCnt+1, wrapping at all ones.
  - Next state is ACQ if contLatch, with a re-latched window, winCnt=0 and cont still honoured. Otherwise IDLE.
- start while busy is ignored. stop in IDLE, FLUSH or STROBE only clears contLatch.
- Counters use unsigned wrap arithmetic; winCnt is width winBit+1; binCnt is width binBit+1.

Decomposition:
- Shared package g2_pkg:
  - state enum g2AcqState_t (IDLE, ACQ, FLUSH, STROBE, DUMP, DONE).
  - constants G2_BINS and G2_FLUSH_MIN.
- One natural sub-module, g2_stream_gate: the valid/ready gating for one stream, instantiated twice.
- The FSM and counters stay in the top module.

Test Plan:
- cfgWindow=100, cont=0, a1Vi=a2Vi=a1Ro=a2Ro=1, start pulse.
  - a1Vo high for exactly 100 cycles.
  - histRst low for 1 cycle, 16 cycles after the window.
  - 1024 out handshakes, outBin 0..1023, outLast only on 1023.
  - frameCnt=1, back in IDLE.
- cfgWindow=1000, stop at cycle 37 of ACQ -> gating closes after 38 cycles; full 1024-bin dump still occurs; frameCnt=1.
- cont=1, cfgWindow=50, stop asserted during the second DUMP -> second dump completes; frameCnt=2; IDLE; no third ACQ.
- Dump with outR toggling 1/0 every cycle and g2V=1 -> 1024 accepted beats; g2R mirrors outR; no duplicate or skipped outBin.
- RST low mid-ACQ at cycle 20 -> all outputs at reset values immediately; histRst=1; start after release gives a clean frame with frameCnt=1.
- cfgWindow=0 -> exactly 1 ACQ cycle; start held high during the frame causes no restart until IDLE.
